// File: rtl/word_narrow_serializer_pkg.sv
// word_narrow_serializer_pkg: shared widths, saturation limits and FSM encoding.
package word_narrow_serializer_pkg;
    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam logic [HALF_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [HALF_W-1:0] SAT_MIN = 16'h8000;
    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, SEND_SAT} state_t;
endpackage

// File: rtl/word_narrow_serializer_sat_narrow.sv
// sat_narrow: saturate a signed 32-bit word into a signed halfword, flagging overflow.
module sat_narrow
    import word_narrow_serializer_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [HALF_W-1:0] half,
    output logic              ovf
);
    // The word fits iff every bit from the sign down to the halfword sign matches.
    assign ovf  = !(&word[WORD_W-1:HALF_W-1] || ~|word[WORD_W-1:HALF_W-1]);
    assign half = ovf ? (word[WORD_W-1] ? SAT_MIN : SAT_MAX) : word[HALF_W-1:0];
endmodule

// File: rtl/word_narrow_serializer.sv
// word_narrow_serializer: splits 32-bit words into 16-bit beats, or one saturated beat.
// The saturated-narrow path exists only when SAT_NARROW_EN is defined.
module word_narrow_serializer
    import word_narrow_serializer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_narrow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HALF_W-1:0] out_data,
    output logic              out_last,
    output logic              out_ovf
);
    state_t state, state_n;
    logic [WORD_W-1:0] word, word_n;
    logic narrow, fire_out, accept, sat_ovf;
    logic [HALF_W-1:0] sat_half;
`ifdef SAT_NARROW_EN
    assign narrow = in_narrow;
    sat_narrow u_sat (.word(word), .half(sat_half), .ovf(sat_ovf));
`else
    logic unused_narrow;
    assign unused_narrow = in_narrow;
    assign narrow   = 1'b0;
    assign sat_half = '0;
    assign sat_ovf  = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            word  <= '0;
        end else begin
            state <= state_n;
            word  <= word_n;
        end
    end
    // A last beat leaving frees the slot, so a new word can load in the same cycle.
    always_comb begin
        out_valid = state != IDLE;
        out_last  = state == SEND_HI || state == SEND_SAT;
        out_ovf   = state == SEND_SAT && sat_ovf;
        out_data  = state == SEND_HI ? word[WORD_W-1:HALF_W] :
                    state == SEND_SAT ? sat_half :
                    out_valid ? word[HALF_W-1:0] : '0;
        fire_out  = out_valid && out_ready;
        in_ready  = reset && (state == IDLE || (fire_out && out_last));
        accept    = in_valid && in_ready;
        state_n   = fire_out ? (state == SEND_LO ? SEND_HI : IDLE) : state;
        word_n    = word;
        if (accept) begin
            state_n = narrow ? SEND_SAT : SEND_LO;
            word_n  = in_data;
        end
    end
endmodule

// File: tb/tb_word_narrow_serializer.sv
// tb_word_narrow_serializer: directed and random checks against a beat-queue reference model.
// Saturation cases are exercised only when SAT_NARROW_EN is defined.
module tb_word_narrow_serializer;
`ifdef SAT_NARROW_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        o;
        logic [31:0] w;
        logic        n;
    } beat_t;

    logic clk = 0, reset = 0, in_valid = 0, in_narrow = 0, out_ready = 0;
    logic [31:0] in_data = '0;
    logic in_ready, out_valid, out_last, out_ovf;
    logic [15:0] out_data;
    int vec = 0, miss = 0, beats = 0;
    beat_t q[$];

    word_narrow_serializer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_narrow(in_narrow), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected beats of one word, from the signed value of the word.
    function automatic void push_word(input logic [31:0] w, input logic n);
        int signed v;
        v = $signed(w);
        if (n && SAT) begin
            if (v > 32767) q.push_back('{16'h7FFF, 1'b1, 1'b1, w, 1'b1});
            else if (v < -32768) q.push_back('{16'h8000, 1'b1, 1'b1, w, 1'b1});
            else q.push_back('{w[15:0], 1'b1, 1'b0, w, 1'b1});
        end else begin
            q.push_back('{w[15:0], 1'b0, 1'b0, w, 1'b0});
            q.push_back('{w[31:16], 1'b1, 1'b0, w, 1'b0});
        end
    endfunction

    function automatic bit model_ready();
        return q.size() == 0 || (out_ready && q.size() == 1);
    endfunction

    // Inputs are driven 1 time unit after posedge; outputs are sampled mid-cycle.
    task automatic cyc();
        bit acc;
        #4;
        if (reset) begin
            acc = in_valid && model_ready();
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, model_ready());
            if (q.size() != 0) begin
                chk("out_data", out_data, q[0].d);
                chk("out_last", out_last, q[0].l);
                chk("out_ovf", out_ovf, q[0].o);
                if (out_ready) begin
                    if (q[0].n && !q[0].o)
                        chk("roundtrip", {{16{out_data[15]}}, out_data}, q[0].w);
                    void'(q.pop_front());
                    beats++;
                end
            end
            if (acc) push_word(in_data, in_narrow);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int b0, idx;
        bit acc;
        logic [31:0] w3 [3];
        logic [31:0] sat_w [4];
        @(posedge clk);
        #1;
        #4;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_ovf", out_ovf, 0);
        @(posedge clk);
        #1;
        reset = 1;
        cyc();

        in_valid = 1; in_data = 32'h1234ABCD; in_narrow = 0; out_ready = 1;
        cyc();
        drain();

        in_valid = 1; in_data = 32'h1234ABCD; in_narrow = 0; out_ready = 1;
        cyc();
        in_data = 32'hDEADBEEF; in_narrow = 1; out_ready = 0;
        repeat (3) cyc();
        chk("bp_held", out_data, 16'hABCD);
        drain();

        if (SAT) begin
            sat_w = '{32'h00007FFF, 32'h00008000, 32'hFFFF8000, 32'h80000000};
            foreach (sat_w[i]) begin
                in_valid = 1; in_data = sat_w[i]; in_narrow = 1; out_ready = 1;
                cyc();
                in_valid = 0;
                cyc();
            end
            drain();
        end

        w3 = '{32'h11112222, 32'h33334444, 32'h55556666};
        idx = 0;
        b0 = beats;
        out_ready = 1;
        in_narrow = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = idx < 3;
            in_data = idx < 3 ? w3[idx] : 32'h0;
            acc = in_valid && model_ready();
            cyc();
            if (acc) idx++;
        end
        chk("b2b_beats", beats - b0, 6);
        drain();

        in_valid = 1; in_data = 32'hCAFEF00D; in_narrow = 0; out_ready = 1;
        cyc();
        in_valid = 0;
        cyc();
        reset = 0;
        @(posedge clk);
        #1;
        q.delete();
        #4;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1;
        cyc();

        for (int i = 0; i < 80; i++) begin
            in_valid = 1'($urandom % 2);
            in_narrow = 1'($urandom % 2);
            in_data = ($urandom % 2) ? {{16{1'($urandom % 2)}}, 16'($urandom)} : $urandom;
            if (in_data[31:16] == 16'h0000 || in_data[31:16] == 16'hFFFF)
                in_data[31:16] = {16{in_data[15]}};
            out_ready = ($urandom % 4) != 0;
            cyc();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
